// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rf_write_arbiter
//  Description : Round-robin arbiter sharing the single register_file write
//                port among N_REQ valid/ready requesters. Grants are
//                combinational (same cycle as valid); the winning address and
//                data are registered onto the register_file write pins.
//  Revision    : 1.0  initial release
// ============================================================================
module rf_write_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        arb_en,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*ADDR_W-1:0]     req_addr,
    input  logic [N_REQ*DATA_W-1:0]     req_data,
    output logic [N_REQ-1:0]            req_ready,
    output logic [ADDR_W-1:0]           WriteAddress,
    output logic [DATA_W-1:0]           WriteData,
    output logic                        ReadWriteEn,
    output logic [$clog2(N_REQ)-1:0]    grant_id,
    output logic                        busy
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam logic [PTR_W-1:0] c_LAST = PTR_W'(N_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [PTR_W-1:0]       r_rr_ptr;
    logic [PTR_W-1:0]       r_grant_id;
    logic [ADDR_W-1:0]      r_wr_addr;
    logic [DATA_W-1:0]      r_wr_data;

    logic [N_REQ-1:0]       w_ready;
    logic                   w_found;
    logic [PTR_W-1:0]       w_winner;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic [DATA_W-1:0]      w_sel_data;
    logic                   w_xfer;

    // Cyclic slot index: rr_ptr + offset, wrapped back into 0..N_REQ-1.
    function automatic int f_slot(input int base, input int off);
        int s;
        s = base + off;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return s;
    endfunction

    // Round-robin search starting at rr_ptr; first valid requester wins.
    always_comb begin
        w_ready    = '0;
        w_found    = 1'b0;
        w_winner   = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        if (arb_en && !rst) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!w_found && req_valid[f_slot(int'(r_rr_ptr), k)]) begin
                    w_found    = 1'b1;
                    w_winner   = PTR_W'(f_slot(int'(r_rr_ptr), k));
                    w_ready[f_slot(int'(r_rr_ptr), k)] = 1'b1;
                    w_sel_addr = req_addr[f_slot(int'(r_rr_ptr), k)*ADDR_W +: ADDR_W];
                    w_sel_data = req_data[f_slot(int'(r_rr_ptr), k)*DATA_W +: DATA_W];
                end
            end
        end
    end

    // A grant is only ever raised against an asserted valid, so a grant is a transfer.
    assign w_xfer = w_found;

    // Next-state logic: every transfer edge starts (or continues) a write cycle.
    always_comb begin
        w_state_next = ST_IDLE;
        if (w_xfer) begin
            w_state_next = ST_WRITE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Issue stage: capture the winner's address/data and advance the pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
        end else if (w_xfer) begin
            r_wr_addr  <= w_sel_addr;
            r_wr_data  <= w_sel_data;
            r_grant_id <= w_winner;
            r_rr_ptr   <= (w_winner == c_LAST) ? '0 : w_winner + 1'b1;
        end
    end

    // rst also masks the write strobe in the cycle it is asserted, so a write
    // already sitting on the pins is dropped rather than reaching the register file.
    assign ReadWriteEn  = (r_state != ST_WRITE) || rst;
    assign busy         = (r_state == ST_WRITE) && !rst;
    assign req_ready    = w_ready;
    assign WriteAddress = r_wr_addr;
    assign WriteData    = r_wr_data;
    assign grant_id     = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_write_arbiter
//  Description : Directed, table-driven self-checking bench for
//                rf_write_arbiter with a behavioural register_file model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rf_write_arbiter;

    localparam int N_REQ  = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic                       clk;
    logic                       rst;
    logic                       arb_en;
    logic [N_REQ-1:0]           req_valid;
    logic [N_REQ*ADDR_W-1:0]    req_addr;
    logic [N_REQ*DATA_W-1:0]    req_data;
    logic [N_REQ-1:0]           req_ready;
    logic [ADDR_W-1:0]          WriteAddress;
    logic [DATA_W-1:0]          WriteData;
    logic                       ReadWriteEn;
    logic [1:0]                 grant_id;
    logic                       busy;

    rf_write_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .arb_en       (arb_en),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .WriteAddress (WriteAddress),
        .WriteData    (WriteData),
        .ReadWriteEn  (ReadWriteEn),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register_file: writes on posedge when ReadWriteEn is low.
    logic [DATA_W-1:0] rf_m [32];
    always @(posedge clk) begin
        if (ReadWriteEn === 1'b0) rf_m[WriteAddress] <= WriteData;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; arb_en = 1'b1;
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        rst;
        logic        en;
        logic [3:0]  valid;
        logic [3:0]  exp_ready;
        logic        exp_rwe;
        logic [4:0]  exp_wa;
        logic [31:0] exp_wd;
        logic [1:0]  exp_gid;
        logic        exp_busy;
    } vec_t;

    localparam int N_VEC = 17;
    vec_t tbl [N_VEC];

    initial begin
        // rst, en, valid, ready | after edge: rwe, wa, wd, gid, busy
        // Requester i offers addr 8+i, data 0xA0+i throughout the table.
        tbl[0]  = '{1'b1, 1'b1, 4'b1111, 4'b0000, 1'b1, 5'd0,  32'h00, 2'd0, 1'b0}; // reset
        tbl[1]  = '{1'b1, 1'b1, 4'b1111, 4'b0000, 1'b1, 5'd0,  32'h00, 2'd0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 4'b1111, 4'b0001, 1'b0, 5'd8,  32'hA0, 2'd0, 1'b1}; // fairness
        tbl[3]  = '{1'b0, 1'b1, 4'b1111, 4'b0010, 1'b0, 5'd9,  32'hA1, 2'd1, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 4'b1111, 4'b0100, 1'b0, 5'd10, 32'hA2, 2'd2, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 4'b1111, 4'b1000, 1'b0, 5'd11, 32'hA3, 2'd3, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 4'b1111, 4'b0001, 1'b0, 5'd8,  32'hA0, 2'd0, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 4'b1111, 4'b0010, 1'b0, 5'd9,  32'hA1, 2'd1, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 4'b0100, 4'b0100, 1'b0, 5'd10, 32'hA2, 2'd2, 1'b1}; // ptr->3
        tbl[9]  = '{1'b0, 1'b1, 4'b0110, 4'b0010, 1'b0, 5'd9,  32'hA1, 2'd1, 1'b1}; // wrap
        tbl[10] = '{1'b0, 1'b1, 4'b0100, 4'b0100, 1'b0, 5'd10, 32'hA2, 2'd2, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 5'd10, 32'hA2, 2'd2, 1'b0}; // idle hold
        tbl[12] = '{1'b0, 1'b1, 4'b1000, 4'b1000, 1'b0, 5'd11, 32'hA3, 2'd3, 1'b1}; // late req3
        tbl[13] = '{1'b0, 1'b0, 4'b1111, 4'b0000, 1'b1, 5'd11, 32'hA3, 2'd3, 1'b0}; // arb_en=0
        tbl[14] = '{1'b0, 1'b0, 4'b1111, 4'b0000, 1'b1, 5'd11, 32'hA3, 2'd3, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 4'b1110, 4'b0010, 1'b0, 5'd9,  32'hA1, 2'd1, 1'b1}; // ptr held at 0
        tbl[16] = '{1'b1, 1'b1, 4'b1111, 4'b0000, 1'b1, 5'd0,  32'h00, 2'd0, 1'b0}; // reset again
    end

    initial begin
        for (int a = 0; a < 32; a++) rf_m[a] = 32'hDEAD_0000 + 32'(a);
        rst = 1'b1; arb_en = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
        #1;

        // ---------------- table-driven section ----------------
        for (int i = 0; i < N_REQ; i++) set_req(i, 5'(8 + i), 32'hA0 + 32'(i));
        for (int v = 0; v < N_VEC; v++) begin
            rst = tbl[v].rst; arb_en = tbl[v].en; req_valid = tbl[v].valid;
            #1;
            chk($sformatf("v%0d req_ready", v), 32'(req_ready), 32'(tbl[v].exp_ready));
            step();
            chk($sformatf("v%0d ReadWriteEn", v), 32'(ReadWriteEn), 32'(tbl[v].exp_rwe));
            chk($sformatf("v%0d WriteAddress", v), 32'(WriteAddress), 32'(tbl[v].exp_wa));
            chk($sformatf("v%0d WriteData", v), WriteData, tbl[v].exp_wd);
            chk($sformatf("v%0d grant_id", v), 32'(grant_id), 32'(tbl[v].exp_gid));
            chk($sformatf("v%0d busy", v), 32'(busy), 32'(tbl[v].exp_busy));
        end
        rst = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
        step();

        // ---------------- T2: single requester ----------------
        do_reset();
        set_req(0, 5'd0, 32'd10);
        req_valid = 4'b0001;
        #1;
        chk("t2 req_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        chk("t2 WriteAddress", 32'(WriteAddress), 32'd0);
        chk("t2 WriteData", WriteData, 32'd10);
        chk("t2 ReadWriteEn", 32'(ReadWriteEn), 32'd0);
        step();
        chk("t2 ReadWriteEn idle", 32'(ReadWriteEn), 32'd1);
        chk("t2 rf[0]", rf_m[0], 32'd10);

        // ---------------- T5: same address, two requesters ----------------
        do_reset();
        set_req(0, 5'd1, 32'd20);
        set_req(2, 5'd1, 32'd30);
        req_valid = 4'b0101;
        #1;
        chk("t5 ready first", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b0100;
        chk("t5 WriteData first", WriteData, 32'd20);
        #1;
        chk("t5 ready second", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        chk("t5 WriteData second", WriteData, 32'd30);
        chk("t5 ReadWriteEn b2b", 32'(ReadWriteEn), 32'd0);
        chk("t5 rf[1] mid", rf_m[1], 32'd20);
        step();
        chk("t5 rf[1] final", rf_m[1], 32'd30);

        // ---------------- T6: reset discards in-flight write ----------------
        do_reset();
        set_req(1, 5'd4, 32'd77);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        step();
        chk("t6 rf[4] preload", rf_m[4], 32'd77);
        set_req(0, 5'd4, 32'd55);
        set_req(3, 5'd6, 32'd66);
        req_valid = 4'b0001;
        #1;
        chk("t6 ready handshake", 32'(req_ready), 32'h1);
        step();
        // write of 55 is now on the pins; reset it away with req3 presented
        req_valid = 4'b1000;
        rst = 1'b1;
        #1;
        chk("t6 ReadWriteEn under rst", 32'(ReadWriteEn), 32'd1);
        chk("t6 ready under rst", 32'(req_ready), 32'h0);
        step();
        rst = 1'b0;
        chk("t6 ReadWriteEn after rst", 32'(ReadWriteEn), 32'd1);
        chk("t6 rf[4] unchanged", rf_m[4], 32'd77);
        #1;
        chk("t6 pending req3 ready", 32'(req_ready), 32'h8);
        step();
        req_valid = '0;
        chk("t6 req3 WriteData", WriteData, 32'd66);
        chk("t6 req3 grant_id", 32'(grant_id), 32'd3);
        step();
        chk("t6 rf[6]", rf_m[6], 32'd66);
        chk("t6 rf[4] final", rf_m[4], 32'd77);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
